// File: rtl/axi_mem_port_arbiter_if.sv
// Memory-port bundle between the AXI write/read controllers, the arbiter and the SRAM.
// Handshake: a requester raises *_valid_i and holds its address/data until the
// same-cycle *_grant_o is high; the access completes at that clock edge. A valid
// dropped before a grant is simply withdrawn. There is no back-pressure on read return.
interface axi_mem_port_arbiter_if #(
    parameter int MEM_ADDR_WIDTH = 13,
    parameter int DATA_WIDTH     = 64,
    parameter int NUMBYTES       = DATA_WIDTH / 8
);
    logic                      wr_valid_i;
    logic                      wr_grant_o;
    logic                      wr_cen_i;
    logic                      wr_wen_i;
    logic [MEM_ADDR_WIDTH-1:0] wr_a_i;
    logic [DATA_WIDTH-1:0]     wr_d_i;
    logic [NUMBYTES-1:0]       wr_be_i;

    logic                      rd_valid_i;
    logic                      rd_grant_o;
    logic                      rd_cen_i;
    logic                      rd_wen_i;
    logic [MEM_ADDR_WIDTH-1:0] rd_a_i;
    logic [DATA_WIDTH-1:0]     rd_q_o;
    logic                      rd_rvalid_o;

    logic                      MEM_CEN_o;
    logic                      MEM_WEN_o;
    logic [MEM_ADDR_WIDTH-1:0] MEM_A_o;
    logic [DATA_WIDTH-1:0]     MEM_D_o;
    logic [NUMBYTES-1:0]       MEM_BE_o;
    logic [DATA_WIDTH-1:0]     MEM_Q_i;

    modport slave (
        input  wr_valid_i, wr_cen_i, wr_wen_i, wr_a_i, wr_d_i, wr_be_i,
        input  rd_valid_i, rd_cen_i, rd_wen_i, rd_a_i,
        input  MEM_Q_i,
        output wr_grant_o, rd_grant_o, rd_q_o, rd_rvalid_o,
        output MEM_CEN_o, MEM_WEN_o, MEM_A_o, MEM_D_o, MEM_BE_o
    );

    modport master (
        output wr_valid_i, wr_cen_i, wr_wen_i, wr_a_i, wr_d_i, wr_be_i,
        output rd_valid_i, rd_cen_i, rd_wen_i, rd_a_i,
        output MEM_Q_i,
        input  wr_grant_o, rd_grant_o, rd_q_o, rd_rvalid_o,
        input  MEM_CEN_o, MEM_WEN_o, MEM_A_o, MEM_D_o, MEM_BE_o
    );
endinterface

// File: rtl/axi_mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between AXI write and read controllers.
// Optional bounded burst hold enabled by defining HOLD_EN (uses MAX_HOLD).
module axi_mem_port_arbiter #(
    parameter int MEM_ADDR_WIDTH = 13,
    parameter int DATA_WIDTH     = 64,
    parameter int NUMBYTES       = DATA_WIDTH / 8,
    parameter int MAX_HOLD       = 8
) (
    input logic                   clk,
    input logic                   rst,
    axi_mem_port_arbiter_if.slave bus
);
    localparam logic [0:0] OWNER_WR = 1'b0;
    localparam logic [0:0] OWNER_RD = 1'b1;

    logic [0:0]                last_q, last_d;
    logic                      rvld_q, rvld_d;
    logic                      hold;
    logic [0:0]                contest_owner;
    logic [0:0]                winner;
    logic                      grant_wr, grant_rd, any_grant;
    logic                      mem_cen, mem_wen;
    logic [MEM_ADDR_WIDTH-1:0] mem_a;
    logic [DATA_WIDTH-1:0]     mem_d;
    logic [NUMBYTES-1:0]       mem_be;

`ifdef HOLD_EN
    localparam int             CNT_W   = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD);

    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    // A zero count means the previous cycle was idle, so no burst is in progress.
    assign hold = (hold_cnt_q != '0) && (hold_cnt_q < CNT_MAX);

    always_comb begin
        hold_cnt_d = '0;
        if (any_grant) begin
            if (winner == last_q) begin
                hold_cnt_d = (hold_cnt_q == CNT_MAX) ? CNT_MAX : hold_cnt_q + 1'b1;
            end else begin
                hold_cnt_d = CNT_W'(1);
            end
        end
    end
`else
    // Without hold, contested cycles always alternate and MAX_HOLD has no effect.
    assign hold = 1'b0 && (MAX_HOLD > 0);
`endif

    assign contest_owner = hold ? last_q : ~last_q;

    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (!rst) begin
            unique case ({bus.wr_valid_i, bus.rd_valid_i})
                2'b10: grant_wr = 1'b1;
                2'b01: grant_rd = 1'b1;
                2'b11: begin
                    if (contest_owner == OWNER_WR) grant_wr = 1'b1;
                    else                           grant_rd = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign any_grant = grant_wr | grant_rd;
    assign winner    = grant_rd ? OWNER_RD : OWNER_WR;

    // Idle port still presents the write-side address/data so the bus is never X.
    always_comb begin
        mem_cen = 1'b1;
        mem_wen = 1'b1;
        mem_a   = bus.wr_a_i;
        mem_d   = bus.wr_d_i;
        mem_be  = bus.wr_be_i;
        if (grant_wr) begin
            mem_cen = bus.wr_cen_i;
            mem_wen = bus.wr_wen_i;
        end else if (grant_rd) begin
            mem_cen = bus.rd_cen_i;
            mem_wen = bus.rd_wen_i;
            mem_a   = bus.rd_a_i;
        end
    end

    assign last_d = any_grant ? winner : last_q;
    assign rvld_d = grant_rd & ~bus.rd_cen_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= OWNER_RD;
            rvld_q     <= 1'b0;
`ifdef HOLD_EN
            hold_cnt_q <= '0;
`endif
        end else begin
            last_q     <= last_d;
            rvld_q     <= rvld_d;
`ifdef HOLD_EN
            hold_cnt_q <= hold_cnt_d;
`endif
        end
    end

    assign bus.wr_grant_o  = grant_wr;
    assign bus.rd_grant_o  = grant_rd;
    assign bus.MEM_CEN_o   = mem_cen;
    assign bus.MEM_WEN_o   = mem_wen;
    assign bus.MEM_A_o     = mem_a;
    assign bus.MEM_D_o     = mem_d;
    assign bus.MEM_BE_o    = mem_be;
    assign bus.rd_q_o      = bus.MEM_Q_i;
    assign bus.rd_rvalid_o = rvld_q & ~rst;
endmodule

// File: tb/tb_axi_mem_port_arbiter.sv
// Self-checking bench for axi_mem_port_arbiter: directed scenarios plus random contention
// checked against a history-based arbitration model and a reference memory image.
module tb_axi_mem_port_arbiter;
    localparam int AW = 13;
    localparam int DW = 64;
    localparam int BW = DW / 8;
    localparam int MH = 4;
    localparam int VW = 4 + AW;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    axi_mem_port_arbiter_if #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUMBYTES(BW)) bus ();

    axi_mem_port_arbiter #(
        .MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUMBYTES(BW), .MAX_HOLD(MH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM behavioural model, one-cycle read latency.
    logic [DW-1:0] sram [0:(1<<AW)-1];
    logic [DW-1:0] sram_q;
    assign bus.MEM_Q_i = sram_q;
    always @(posedge clk) begin
        if (!bus.MEM_CEN_o) begin
            if (!bus.MEM_WEN_o) begin
                for (int b = 0; b < BW; b++)
                    if (bus.MEM_BE_o[b]) sram[bus.MEM_A_o][8*b +: 8] <= bus.MEM_D_o[8*b +: 8];
            end else begin
                sram_q <= sram[bus.MEM_A_o];
            end
        end
    end

    // Reference model: previous owner, length of its current run, pending read return.
    logic [DW-1:0] ref_mem [0:63];
    logic [DW-1:0] exp_q[$];
    bit            m_last;
    int            m_run;
    bit            m_rvld;

    function automatic logic [1:0] decide(input logic wv, input logic rv, input logic r);
        bit keep;
        bit owner;
        if (r || (!wv && !rv)) return 2'b00;
        if (wv && !rv) return 2'b10;
        if (rv && !wv) return 2'b01;
        keep = 1'b0;
`ifdef HOLD_EN
        keep = (m_run > 0) && (m_run < MH);
`endif
        owner = keep ? m_last : !m_last;
        return owner ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {bus.wr_grant_o, bus.rd_grant_o, bus.MEM_CEN_o, bus.MEM_WEN_o, bus.MEM_A_o};
    endfunction

    task automatic expect_now(output logic [VW-1:0] ev, output logic erv, output logic [DW-1:0] eq);
        logic [1:0] g;
        g = decide(bus.wr_valid_i, bus.rd_valid_i, rst);
        if (g == 2'b10)      ev = {2'b10, bus.wr_cen_i, bus.wr_wen_i, bus.wr_a_i};
        else if (g == 2'b01) ev = {2'b01, bus.rd_cen_i, bus.rd_wen_i, bus.rd_a_i};
        else                 ev = {2'b00, 1'b1, 1'b1, bus.wr_a_i};
        erv = m_rvld && !rst;
        eq  = (exp_q.size() > 0) ? exp_q[0] : '0;
    endtask

    task automatic tick(output logic [1:0] g);
        logic r, wc, ww, rc;
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd;
        logic [BW-1:0] be;
        bit owner;
        g  = decide(bus.wr_valid_i, bus.rd_valid_i, rst);
        r  = rst;
        wc = bus.wr_cen_i; ww = bus.wr_wen_i; wa = bus.wr_a_i; wd = bus.wr_d_i; be = bus.wr_be_i;
        rc = bus.rd_cen_i; ra = bus.rd_a_i;
        @(posedge clk);
        if (m_rvld && exp_q.size() > 0) void'(exp_q.pop_front());
        if (r) begin
            m_last = 1'b1;
            m_run  = 0;
            m_rvld = 1'b0;
            exp_q.delete();
        end else begin
            m_rvld = (g == 2'b01) && !rc;
            if (m_rvld) exp_q.push_back(ref_mem[ra[5:0]]);
            if (g == 2'b10 && !wc && !ww)
                for (int b = 0; b < BW; b++)
                    if (be[b]) ref_mem[wa[5:0]][8*b +: 8] = wd[8*b +: 8];
            if (g == 2'b00) begin
                m_run = 0;
            end else begin
                owner = (g == 2'b01);
                if (owner == m_last) m_run++;
                else begin
                    m_last = owner;
                    m_run  = 1;
                end
            end
        end
        #1;
    endtask

    // Driver tasks.
    task automatic drive_wr(input logic v, input logic cen, input logic [AW-1:0] a);
        bus.wr_valid_i = v;
        bus.wr_cen_i   = cen;
        bus.wr_wen_i   = 1'b0;
        bus.wr_a_i     = a;
        bus.wr_d_i     = {$urandom, $urandom};
        bus.wr_be_i    = BW'($urandom);
    endtask

    task automatic drive_rd(input logic v, input logic cen, input logic [AW-1:0] a);
        bus.rd_valid_i = v;
        bus.rd_cen_i   = cen;
        bus.rd_wen_i   = 1'b1;
        bus.rd_a_i     = a;
    endtask

    task automatic test_reset();
        logic [1:0] g;
        rst = 1'b1;
        drive_wr(1'b1, 1'b0, 13'h030);
        drive_rd(1'b1, 1'b0, 13'h011);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if ({bus.wr_grant_o, bus.rd_grant_o, bus.MEM_CEN_o, bus.MEM_WEN_o, bus.rd_rvalid_o} !== 5'b00110) begin
                bad++;
                $display("FAIL reset cyc=%0d got wg/rg/cen/wen/rv=%b exp=00110", i,
                         {bus.wr_grant_o, bus.rd_grant_o, bus.MEM_CEN_o, bus.MEM_WEN_o, bus.rd_rvalid_o});
            end
            tick(g);
        end
        rst = 1'b0;
    endtask

    task automatic test_alternation();
        logic [VW-1:0] ev; logic erv; logic [DW-1:0] eq; logic [1:0] g;
        for (int i = 0; i < 6; i++) begin
            drive_wr(i < 4, 1'b0, 13'h030);
            drive_rd(i < 4, 1'b0, AW'(32 + i));
            @(negedge clk);
            expect_now(ev, erv, eq);
            total++;
            if (obs_vec() !== ev) begin
                bad++; $display("FAIL alternation cyc=%0d got=%h exp=%h", i, obs_vec(), ev);
            end
            total++;
            if (bus.rd_rvalid_o !== erv) begin
                bad++; $display("FAIL alternation_rvalid cyc=%0d got=%b exp=%b", i, bus.rd_rvalid_o, erv);
            end
            if (erv) begin
                total++;
                if (bus.rd_q_o !== eq) begin
                    bad++; $display("FAIL alternation_rdata cyc=%0d got=%h exp=%h", i, bus.rd_q_o, eq);
                end
            end
            tick(g);
        end
    endtask

    task automatic test_read_only();
        logic [1:0] g;
        drive_wr(1'b0, 1'b1, 13'h000);
        drive_rd(1'b1, 1'b0, 13'h010);
        @(negedge clk);
        total++;
        if (bus.rd_grant_o !== 1'b1 || bus.wr_grant_o !== 1'b0 || bus.MEM_A_o !== 13'h010 || bus.MEM_CEN_o !== 1'b0) begin
            bad++;
            $display("FAIL read_only_grant got rg=%b wg=%b a=%h cen=%b exp rg=1 wg=0 a=010 cen=0",
                     bus.rd_grant_o, bus.wr_grant_o, bus.MEM_A_o, bus.MEM_CEN_o);
        end
        tick(g);
        drive_rd(1'b0, 1'b1, 13'h010);
        @(negedge clk);
        total++;
        if (bus.rd_rvalid_o !== 1'b1 || bus.rd_q_o !== 64'h0000_0000_DEAD_BEEF) begin
            bad++;
            $display("FAIL read_only_data got rv=%b q=%h exp rv=1 q=00000000deadbeef", bus.rd_rvalid_o, bus.rd_q_o);
        end
        tick(g);
    endtask

    // pattern: per-cycle {wr_valid, rd_valid}
    task automatic run_pattern(input string name, input logic [1:0] pat[], input int n);
        logic [VW-1:0] ev; logic erv; logic [DW-1:0] eq; logic [1:0] g;
        for (int i = 0; i < n; i++) begin
            drive_wr(pat[i][1], 1'b0, AW'($urandom_range(32, 47)));
            drive_rd(pat[i][0], 1'b0, AW'($urandom_range(32, 47)));
            @(negedge clk);
            expect_now(ev, erv, eq);
            total++;
            if (obs_vec() !== ev) begin
                bad++; $display("FAIL %s cyc=%0d got=%h exp=%h", name, i, obs_vec(), ev);
            end
            total++;
            if (bus.rd_rvalid_o !== erv) begin
                bad++; $display("FAIL %s_rvalid cyc=%0d got=%b exp=%b", name, i, bus.rd_rvalid_o, erv);
            end
            if (erv) begin
                total++;
                if (bus.rd_q_o !== eq) begin
                    bad++; $display("FAIL %s_rdata cyc=%0d got=%h exp=%h", name, i, bus.rd_q_o, eq);
                end
            end
            tick(g);
        end
    endtask

    task automatic test_hold();
        logic [1:0] pat[] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
        run_pattern("hold", pat, 8);
    endtask

    task automatic test_idle_break();
        logic [1:0] pat[] = '{2'b10, 2'b00, 2'b11, 2'b11, 2'b00};
        run_pattern("idle_break", pat, 5);
    endtask

    task automatic test_reset_midburst();
        logic [1:0] g;
        logic [1:0] pat[] = '{2'b11, 2'b11, 2'b11};
        run_pattern("pre_reset", pat, 3);
        rst = 1'b1;
        drive_wr(1'b1, 1'b0, 13'h031);
        drive_rd(1'b1, 1'b0, 13'h021);
        @(negedge clk);
        total++;
        if ({bus.wr_grant_o, bus.rd_grant_o, bus.MEM_CEN_o, bus.MEM_WEN_o, bus.rd_rvalid_o} !== 5'b00110) begin
            bad++;
            $display("FAIL midburst_reset got wg/rg/cen/wen/rv=%b exp=00110",
                     {bus.wr_grant_o, bus.rd_grant_o, bus.MEM_CEN_o, bus.MEM_WEN_o, bus.rd_rvalid_o});
        end
        tick(g);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.wr_grant_o !== 1'b1 || bus.rd_grant_o !== 1'b0) begin
            bad++;
            $display("FAIL after_reset_grant got wg=%b rg=%b exp wg=1 rg=0", bus.wr_grant_o, bus.rd_grant_o);
        end
        tick(g);
    endtask

    task automatic test_idle();
        logic [VW-1:0] ev; logic erv; logic [DW-1:0] eq; logic [1:0] g;
        for (int i = 0; i < 3; i++) begin
            drive_wr(1'b0, 1'b0, 13'h005);
            drive_rd(1'b0, 1'b0, 13'h006);
            @(negedge clk);
            expect_now(ev, erv, eq);
            total++;
            if ({bus.wr_grant_o, bus.rd_grant_o, bus.MEM_CEN_o, bus.MEM_WEN_o, bus.rd_rvalid_o} !== 5'b00110) begin
                bad++;
                $display("FAIL idle cyc=%0d got wg/rg/cen/wen/rv=%b exp=00110", i,
                         {bus.wr_grant_o, bus.rd_grant_o, bus.MEM_CEN_o, bus.MEM_WEN_o, bus.rd_rvalid_o});
            end
            total++;
            if (bus.rd_rvalid_o !== erv) begin
                bad++; $display("FAIL idle_rvalid cyc=%0d got=%b exp=%b", i, bus.rd_rvalid_o, erv);
            end
            tick(g);
        end
    endtask

    task automatic test_random();
        logic [VW-1:0] ev; logic erv; logic [DW-1:0] eq; logic [1:0] g;
        bit wr_pend, rd_pend;
        int wait_w, wait_r;
        wr_pend = 0; rd_pend = 0; wait_w = 0; wait_r = 0;
        for (int i = 0; i < 500; i++) begin
            if (!wr_pend) begin
                drive_wr($urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0, AW'($urandom_range(0, 63)));
                wr_pend = bus.wr_valid_i;
            end
            if (!rd_pend) begin
                drive_rd($urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0, AW'($urandom_range(0, 63)));
                rd_pend = bus.rd_valid_i;
            end
            @(negedge clk);
            expect_now(ev, erv, eq);
            total++;
            if (obs_vec() !== ev) begin
                bad++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_vec(), ev);
            end
            total++;
            if (bus.rd_rvalid_o !== erv) begin
                bad++; $display("FAIL random_rvalid cyc=%0d got=%b exp=%b", i, bus.rd_rvalid_o, erv);
            end
            if (erv) begin
                total++;
                if (bus.rd_q_o !== eq) begin
                    bad++; $display("FAIL random_rdata cyc=%0d got=%h exp=%h", i, bus.rd_q_o, eq);
                end
            end
            if (!ev[VW-2]) begin
                total++;
                if (bus.MEM_D_o !== bus.wr_d_i || bus.MEM_BE_o !== bus.wr_be_i) begin
                    bad++;
                    $display("FAIL random_wdata cyc=%0d got d=%h be=%h exp d=%h be=%h", i,
                             bus.MEM_D_o, bus.MEM_BE_o, bus.wr_d_i, bus.wr_be_i);
                end
            end
            tick(g);
            if (g[1]) begin wr_pend = 0; wait_w = 0; end else if (wr_pend) wait_w++;
            if (g[0]) begin rd_pend = 0; wait_r = 0; end else if (rd_pend) wait_r++;
`ifdef HOLD_EN
            if (wait_w > MH || wait_r > MH) begin
`else
            if (wait_w > 1 || wait_r > 1) begin
`endif
                total++; bad++;
                $display("FAIL starvation cyc=%0d got wait_w=%0d wait_r=%0d exp within bound", i, wait_w, wait_r);
                wait_w = 0; wait_r = 0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            logic [DW-1:0] v;
            v = (i == 16) ? 64'h0000_0000_DEAD_BEEF : {32'h0, 32'hA500_0000 | 32'(i)};
            sram[i] <= v;
            ref_mem[i] = v;
        end
        sram_q = '0;
        m_last = 1'b1; m_run = 0; m_rvld = 1'b0;
        rst = 1'b1;
        drive_wr(1'b0, 1'b1, '0);
        drive_rd(1'b0, 1'b1, '0);
        @(posedge clk); #1;

        test_reset();
        test_alternation();
        test_read_only();
        test_hold();
        test_idle_break();
        test_reset_midburst();
        test_idle();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
